// File: rtl/game_round_sequencer_pkg.sv
// Shared state encodings and switch patterns for the DIP-switch binary game round controller.
package game_round_sequencer_pkg;

    typedef enum logic [2:0] {
        st_idle = 3'd0,
        st_req  = 3'd1,
        st_wait = 3'd2,
        st_load = 3'd3,
        st_play = 3'd4,
        st_over = 3'd5
    } state_t;

    localparam int unsigned data_w      = 8;
    localparam int unsigned lives_w     = 3;
    localparam int unsigned retry_w     = 2;
    localparam int unsigned timer_w     = 16;

    localparam logic [data_w-1:0]  start_pattern = 8'h01;
    localparam logic [data_w-1:0]  clear_pattern = 8'h00;
    localparam logic [retry_w-1:0] max_retries   = 2'd3;

endpackage

// File: rtl/game_round_sequencer_if.sv
// Player/RNG/display signal bundle of the round sequencer; master = sequencer side.
interface game_round_sequencer_if;
    import game_round_sequencer_pkg::*;

    logic [data_w-1:0]  user_input;
    logic [data_w-1:0]  rng_value;
    logic               rng_trigger;
    logic               disp_load;
    logic [data_w-1:0]  target;
    logic [data_w-1:0]  score;
    logic [lives_w-1:0] lives;
    logic               game_active;
    logic               game_over;
    logic               round_hit;

    modport master (
        input  user_input, rng_value,
        output rng_trigger, disp_load, target, score, lives,
               game_active, game_over, round_hit
    );

    modport slave (
        output user_input, rng_value,
        input  rng_trigger, disp_load, target, score, lives,
               game_active, game_over, round_hit
    );
endinterface

// File: rtl/game_round_sequencer_input_stabilizer.sv
// input_stabilizer: flags when din has been unchanged for STABLE_CYCLES consecutive samples.
module input_stabilizer #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic       stable,
    output logic [7:0] dout
);
    localparam int unsigned cnt_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(STABLE_CYCLES - 1);

    logic [cnt_w-1:0] cnt;
    logic [7:0]       prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            prev <= '0;
        end else begin
            prev <= din;
            if (din != prev) begin
                cnt <= '0;
            end else if (cnt != cnt_max) begin
                cnt <= cnt + cnt_w'(1);
            end
        end
    end

    assign stable = (cnt == cnt_max);
    assign dout   = prev;
endmodule

// File: rtl/game_round_sequencer.sv
// Round controller for the DIP-switch binary game: start, RNG target fetch, match scoring, end.
// Optional round timeout with lives is enabled by defining GAME_TIMEOUT_EN.
module game_round_sequencer
    import game_round_sequencer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_ROUNDS    = 16,
    parameter int unsigned ROUND_TIMEOUT = 50000,
    parameter int unsigned START_LIVES   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    game_round_sequencer_if.master bus
);
    localparam logic [data_w-1:0]  rounds_to_win = data_w'(MAX_ROUNDS);
    localparam logic [lives_w-1:0] lives_init    = lives_w'(START_LIVES);

    if (STABLE_CYCLES == 0 || MAX_ROUNDS == 0 || MAX_ROUNDS > 255 ||
        START_LIVES == 0 || START_LIVES > 7 ||
        ROUND_TIMEOUT == 0 || ROUND_TIMEOUT > 65536) begin : g_param_check
        $error("game_round_sequencer: parameter out of range");
    end

    state_t             state;
    logic [data_w-1:0]  target;
    logic [data_w-1:0]  score;
    logic [lives_w-1:0] lives;
    logic [retry_w-1:0] retry;
    logic               rng_trigger;
    logic               disp_load;
    logic               round_hit;
    logic               game_active;
    logic               game_over;

    logic               stable;
    logic [data_w-1:0]  held;
    logic               hit_c;
    logic               reject_c;

`ifdef GAME_TIMEOUT_EN
    localparam logic [timer_w-1:0] timer_last = timer_w'(ROUND_TIMEOUT - 1);
    logic [timer_w-1:0] timer;
`endif

    input_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
        .clk    (clk),
        .rst    (rst),
        .din    (bus.user_input),
        .stable (stable),
        .dout   (held)
    );

    assign hit_c    = stable && (held == target);
    // A target equal to the current switches or zero would be free; re-roll while retries remain.
    assign reject_c = ((bus.rng_value == bus.user_input) || (bus.rng_value == '0)) &&
                      (retry < max_retries);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= st_idle;
            target      <= '0;
            score       <= '0;
            lives       <= lives_init;
            retry       <= '0;
            rng_trigger <= 1'b0;
            disp_load   <= 1'b0;
            round_hit   <= 1'b0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
`ifdef GAME_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            rng_trigger <= 1'b0;
            disp_load   <= 1'b0;
            round_hit   <= 1'b0;
            case (state)
                st_idle: begin
                    if (stable && (held == start_pattern)) begin
                        state       <= st_req;
                        rng_trigger <= 1'b1;
                        score       <= '0;
                        lives       <= lives_init;
                        retry       <= '0;
                        game_active <= 1'b1;
                    end
                end
                st_req:  state <= st_wait;
                st_wait: state <= st_load;
                st_load: begin
                    if (reject_c) begin
                        retry       <= retry + retry_w'(1);
                        state       <= st_req;
                        rng_trigger <= 1'b1;
                    end else begin
                        target    <= bus.rng_value;
                        disp_load <= 1'b1;
                        retry     <= '0;
                        state     <= st_play;
`ifdef GAME_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end
                end
                st_play: begin
                    if (hit_c) begin
                        round_hit <= 1'b1;
                        score     <= score + data_w'(1);
                        if ((score + data_w'(1)) == rounds_to_win) begin
                            state       <= st_over;
                            game_active <= 1'b0;
                            game_over   <= 1'b1;
                        end else begin
                            state       <= st_req;
                            rng_trigger <= 1'b1;
                        end
                    end
`ifdef GAME_TIMEOUT_EN
                    else if (timer == timer_last) begin
                        timer <= '0;
                        if (lives <= lives_w'(1)) begin
                            lives       <= '0;
                            state       <= st_over;
                            game_active <= 1'b0;
                            game_over   <= 1'b1;
                        end else begin
                            lives       <= lives - lives_w'(1);
                            state       <= st_req;
                            rng_trigger <= 1'b1;
                        end
                    end else begin
                        timer <= timer + timer_w'(1);
                    end
`endif
                end
                st_over: begin
                    if (stable && (held == clear_pattern)) begin
                        state     <= st_idle;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state       <= st_idle;
                    game_active <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rng_trigger = rng_trigger;
    assign bus.disp_load   = disp_load;
    assign bus.target      = target;
    assign bus.score       = score;
    assign bus.lives       = lives;
    assign bus.game_active = game_active;
    assign bus.game_over   = game_over;
    assign bus.round_hit   = round_hit;
endmodule

// File: tb/tb_game_round_sequencer.sv
// Scenario bench for game_round_sequencer (MAX_ROUNDS=2, ROUND_TIMEOUT=20, START_LIVES=2).
`timescale 1ns/1ps
module tb_game_round_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    game_round_sequencer_if bus();

    game_round_sequencer #(
        .STABLE_CYCLES (4),
        .MAX_ROUNDS    (2),
        .ROUND_TIMEOUT (20),
        .START_LIVES   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] rng_q[$];
    logic [7:0] exp_target_q[$];

    // RNG stand-in: each request presents the next queued value, held until the next request
    always @(negedge clk) begin
        if (bus.rng_trigger === 1'b1 && rng_q.size() > 0) bus.rng_value = rng_q.pop_front();
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 rng_trigger, 1 disp_load, 2 round_hit, 3 game_over low, 4 game_over high
    task automatic wait_event(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && bus.rng_trigger === 1'b1) ||
                (which == 1 && bus.disp_load   === 1'b1) ||
                (which == 2 && bus.round_hit   === 1'b1) ||
                (which == 3 && bus.game_over   === 1'b0) ||
                (which == 4 && bus.game_over   === 1'b1)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.user_input = 8'h00;
        step(2);
        checks++;
        if ({bus.target, bus.score} !== 16'h0000) begin
            errors++; $display("FAIL reset_target_score got=%h want=0000", {bus.target, bus.score});
        end
        checks++;
        if (bus.lives !== 3'd2) begin
            errors++; $display("FAIL reset_lives got=%0d want=2", bus.lives);
        end
        checks++;
        if ({bus.game_active, bus.game_over, bus.rng_trigger, bus.disp_load, bus.round_hit} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=00000",
                {bus.game_active, bus.game_over, bus.rng_trigger, bus.disp_load, bus.round_hit});
        end
        rst = 1'b0;
    endtask

    task automatic test_start;
        int n;
        logic [7:0] exp;
        rng_q.push_back(8'h2A);
        exp_target_q.push_back(8'h2A);
        bus.user_input = 8'h01;
        wait_event(0, 20, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL start_to_trigger got=%0d want=5", n); end
        wait_event(1, 20, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL trigger_to_load got=%0d want=3", n); end
        if (n > 0) begin
            exp = exp_target_q.pop_front();
            checks++;
            if (bus.target !== exp) begin errors++; $display("FAIL start_target got=%h want=%h", bus.target, exp); end
        end
        checks++;
        if ({bus.game_active, bus.game_over, bus.score} !== {2'b10, 8'd0}) begin
            errors++; $display("FAIL start_status got=%b/%0d want=10/0", {bus.game_active, bus.game_over}, bus.score);
        end
    endtask

    task automatic test_glitch_hit;
        int n;
        rng_q.push_back(8'h2A);
        rng_q.push_back(8'h00);
        rng_q.push_back(8'h2A);
        rng_q.push_back(8'h2A);
        exp_target_q.push_back(8'h2A);
        bus.user_input = 8'h2A;
        step(1);
        bus.user_input = 8'h2B;
        step(1);
        bus.user_input = 8'h2A;
        wait_event(2, 20, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL glitch_hit_latency got=%0d want=5", n); end
        checks++;
        if (bus.score !== 8'd1) begin errors++; $display("FAIL hit_score got=%0d want=1", bus.score); end
        checks++;
        if (bus.rng_trigger !== 1'b1) begin errors++; $display("FAIL hit_trigger got=%b want=1", bus.rng_trigger); end
    endtask

    task automatic test_retry;
        int n;
        int trig;
        logic [7:0] exp;
        n = -1;
        trig = 1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.rng_trigger === 1'b1) trig++;
            if (bus.disp_load === 1'b1) begin n = i; break; end
        end
        checks++;
        if (trig !== 4) begin errors++; $display("FAIL retry_triggers got=%0d want=4", trig); end
        checks++;
        if (n !== 12) begin errors++; $display("FAIL retry_latency got=%0d want=12", n); end
        if (n > 0) begin
            exp = exp_target_q.pop_front();
            checks++;
            if (bus.target !== exp) begin errors++; $display("FAIL retry_target got=%h want=%h", bus.target, exp); end
        end
    endtask

    task automatic test_max_rounds;
        int n;
        wait_event(2, 5, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL final_hit_latency got=%0d want=1", n); end
        checks++;
        if ({bus.game_over, bus.game_active, bus.rng_trigger, bus.score} !== {3'b100, 8'd2}) begin
            errors++; $display("FAIL game_over_status got=%b/%0d want=100/2",
                {bus.game_over, bus.game_active, bus.rng_trigger}, bus.score);
        end
        bus.user_input = 8'h55;
        step(8);
        checks++;
        if ({bus.game_over, bus.score, bus.target} !== {1'b1, 8'd2, 8'h2A}) begin
            errors++; $display("FAIL over_hold got=%b/%0d/%h want=1/2/2a", bus.game_over, bus.score, bus.target);
        end
        bus.user_input = 8'h00;
        wait_event(3, 20, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL clear_to_idle got=%0d want=5", n); end
    endtask

    task automatic test_reset_mid_game;
        int n;
        logic [7:0] exp;
        rng_q.push_back(8'h77);
        exp_target_q.push_back(8'h77);
        bus.user_input = 8'h01;
        wait_event(0, 20, n);
        checks++;
        if (n !== 5 || bus.score !== 8'd0) begin
            errors++; $display("FAIL restart got=%0d/%0d want=5/0", n, bus.score);
        end
        wait_event(1, 20, n);
        if (n > 0) begin
            exp = exp_target_q.pop_front();
            checks++;
            if (bus.target !== exp) begin errors++; $display("FAIL restart_target got=%h want=%h", bus.target, exp); end
        end
        rng_q.push_back(8'h10);
        exp_target_q.push_back(8'h10);
        bus.user_input = 8'h77;
        wait_event(2, 20, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL second_hit_latency got=%0d want=5", n); end
        wait_event(1, 20, n);
        if (n > 0) begin
            exp = exp_target_q.pop_front();
            checks++;
            if (bus.target !== exp) begin errors++; $display("FAIL second_target got=%h want=%h", bus.target, exp); end
        end
        rst = 1'b1;
        step(1);
        checks++;
        if ({bus.score, bus.target, bus.game_active, bus.rng_trigger, bus.disp_load, bus.round_hit} !== 20'h0) begin
            errors++; $display("FAIL mid_game_reset got=%0d/%h/%b want=0/00/0000", bus.score, bus.target,
                {bus.game_active, bus.rng_trigger, bus.disp_load, bus.round_hit});
        end
        rst = 1'b0;
    endtask

`ifdef GAME_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        logic [7:0] exp;
        rng_q.push_back(8'h33);
        rng_q.push_back(8'h44);
        exp_target_q.push_back(8'h33);
        exp_target_q.push_back(8'h44);
        bus.user_input = 8'h01;
        wait_event(1, 30, n);
        if (n > 0) begin
            exp = exp_target_q.pop_front();
            checks++;
            if (bus.target !== exp) begin errors++; $display("FAIL timeout_target got=%h want=%h", bus.target, exp); end
        end
        wait_event(0, 40, n);
        checks++;
        if (n !== 20 || bus.lives !== 3'd1) begin
            errors++; $display("FAIL first_timeout got=%0d/%0d want=20/1", n, bus.lives);
        end
        wait_event(1, 20, n);
        if (n > 0) exp = exp_target_q.pop_front();
        wait_event(4, 40, n);
        checks++;
        if (n !== 20 || bus.lives !== 3'd0 || bus.game_active !== 1'b0) begin
            errors++; $display("FAIL second_timeout got=%0d/%0d/%b want=20/0/0", n, bus.lives, bus.game_active);
        end
        bus.user_input = 8'h00;
        wait_event(3, 20, n);
        rng_q.push_back(8'h55);
        rng_q.push_back(8'h66);
        exp_target_q.push_back(8'h55);
        bus.user_input = 8'h01;
        wait_event(1, 30, n);
        if (n > 0) exp = exp_target_q.pop_front();
        step(15);
        bus.user_input = 8'h55;
        wait_event(2, 10, n);
        checks++;
        if (n !== 5 || bus.score !== 8'd1 || bus.lives !== 3'd2) begin
            errors++; $display("FAIL hit_on_timeout got=%0d/%0d/%0d want=5/1/2", n, bus.score, bus.lives);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_glitch_hit();
        test_retry();
        test_max_rounds();
        test_reset_mid_game();
`ifdef GAME_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
